// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns, digit codes, FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK   = 4'hE;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Caller guarantees sel is one-hot; slot 3 is the leftmost digit.
  function automatic logic [1:0] slot_of(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decode; o_valid covers digits 0-9 and blank.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_valid,
  output logic       o_blank,
  output logic [3:0] o_bcd
);

  always_comb begin
    o_valid = 1'b1;
    o_blank = 1'b0;
    o_bcd   = DIGIT_INVALID;
    case (i_pat)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: begin
        o_blank = 1'b1;
        o_bcd   = DIGIT_BLANK;
      end
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan-bus receiver: sync, debounce per slot, decode, publish 4-digit frames; stale/err flags.
// Frame out ~(STABLE_CNT+1)*SAMPLE_DIV+4 clks after last slot settles; no backpressure, frames overwrite.
// SEG_ACTIVE_LOW_EN: invert i_seg at the synchroniser input for common-anode boards.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SAMPLE_DIV = 64,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_bit,
  input  logic [7:0]  i_seg,
  input  logic        i_err_clr,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
  localparam int STB_W = $clog2(STABLE_CNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CNT);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  logic [7:0]       seg_in;
  logic [11:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [STB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [11:0]      prev_key_q, prev_key_d;
  logic [11:0]      acc_key_q, acc_key_d;
  state_t           state_q, state_d;
  logic [3:0][3:0]  shadow_dig_q, shadow_dig_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       mask_q, mask_d;
  logic             pub_chk_q, pub_chk_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       dp_q, dp_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic             strobe, key_onehot, accept, publish;
  logic [11:0]      key;
  logic [1:0]       slot;
  logic [3:0]       acc_digit;
  logic             dec_valid, dec_blank;
  logic [3:0]       dec_bcd;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~i_seg;
`else
  assign seg_in = i_seg;
`endif

  seg7_pattern_decode u_decode (
    .i_pat   (acc_key_q[6:0]),
    .o_valid (dec_valid),
    .o_blank (dec_blank),
    .o_bcd   (dec_bcd)
  );

  always_comb begin
    sync1_d    = {i_bit, seg_in};
    sync2_d    = sync1_q;
    key        = sync2_q;
    key_onehot = is_onehot4(key[11:8]);
    strobe     = (div_cnt_q == DIV_LAST);
    div_cnt_d  = strobe ? '0 : div_cnt_q + DIV_W'(1);

    stab_cnt_d = stab_cnt_q;
    prev_key_d = prev_key_q;
    if (strobe) begin
      prev_key_d = key;
      if (!key_onehot) begin
        stab_cnt_d = '0;
      end else if (key == prev_key_q && stab_cnt_q != '0) begin
        stab_cnt_d = (stab_cnt_q == STB_MAX) ? STB_MAX : stab_cnt_q + STB_W'(1);
      end else begin
        stab_cnt_d = STB_W'(1);
      end
    end

    // HOLD compares against the accepted key, not the previous sample, so a
    // slot change landing on the ACCEPT strobe is still seen as a change.
    state_d   = state_q;
    acc_key_d = acc_key_q;
    accept    = 1'b0;
    if (strobe) begin
      case (state_q)
        IDLE:   if (key_onehot) state_d = SETTLE;
        SETTLE: begin
          if (!key_onehot) begin
            state_d = IDLE;
          end else if (stab_cnt_d == STB_MAX) begin
            state_d   = ACCEPT;
            acc_key_d = key;
          end
        end
        ACCEPT: begin
          accept  = 1'b1;
          state_d = HOLD;
        end
        HOLD: begin
          if (!key_onehot)          state_d = IDLE;
          else if (key != acc_key_q) state_d = SETTLE;
        end
        default: state_d = IDLE;
      endcase
    end

    slot      = slot_of(acc_key_q[11:8]);
    acc_digit = dec_blank ? DIGIT_BLANK : (dec_valid ? dec_bcd : DIGIT_INVALID);

    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    mask_d       = mask_q;
    pub_chk_d    = accept;
    publish      = pub_chk_q && (mask_q == 4'hF);
    if (publish) mask_d = '0;
    if (accept) begin
      shadow_dig_d[slot] = acc_digit;
      shadow_dp_d[slot]  = acc_key_q[7];
      mask_d[slot]       = 1'b1;
    end

    digits_d = publish ? shadow_dig_q : digits_q;
    dp_d     = publish ? shadow_dp_q  : dp_q;
    valid_d  = publish;

    err_d = err_q;
    if (i_err_clr)              err_d = 1'b0;
    if (accept && !dec_valid)   err_d = 1'b1;

    if (accept)                  tmo_cnt_d = '0;
    else if (tmo_cnt_q == TMO_MAX) tmo_cnt_d = TMO_MAX;
    else                         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      div_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      prev_key_q   <= '0;
      acc_key_q    <= '0;
      state_q      <= IDLE;
      shadow_dig_q <= {4{DIGIT_BLANK}};
      shadow_dp_q  <= '0;
      mask_q       <= '0;
      pub_chk_q    <= 1'b0;
      digits_q     <= {4{DIGIT_BLANK}};
      dp_q         <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      div_cnt_q    <= div_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      prev_key_q   <= prev_key_d;
      acc_key_q    <= acc_key_d;
      state_q      <= state_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      mask_q       <= mask_d;
      pub_chk_q    <= pub_chk_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign o_digits = digits_q;
  assign o_dp     = dp_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_stale  = (tmo_cnt_q == TMO_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder; expected frames queued at stimulus time, popped on o_valid.
module tb_seg7_scan_decoder;

  localparam int SD  = 4;
  localparam int SC  = 4;
  localparam int TMO = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_bit;
  logic [7:0]  i_seg;
  logic        i_err_clr;
  logic [15:0] o_digits;
  logic [3:0]  o_dp;
  logic        o_valid;
  logic        o_err;
  logic        o_stale;

  int checks = 0;
  int failures = 0;
  int frames_seen = 0;
  int exp_frames = 0;
  logic [19:0] sb_q[$];
  logic [19:0] exp_e;

  seg7_scan_decoder #(.SAMPLE_DIV(SD), .STABLE_CNT(SC), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_bit     (i_bit),
    .i_seg     (i_seg),
    .i_err_clr (i_err_clr),
    .o_digits  (o_digits),
    .o_dp      (o_dp),
    .o_valid   (o_valid),
    .o_err     (o_err),
    .o_stale   (o_stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] raw(input logic [7:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      frames_seen++;
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected_frame observed=%h expected=no frame", o_digits);
      end
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        chk("frame_digits", 32'(o_digits), 32'(exp_e[19:4]));
        chk("frame_dp", 32'(o_dp), 32'(exp_e[3:0]));
      end
    end
  end

  task automatic slot(input logic [3:0] b, input logic [7:0] s, input int n);
    i_bit = b;
    i_seg = raw(s);
    repeat (n * SD) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_bit = 4'h0;
    i_seg = raw(8'h00);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [15:0] ed, input logic [3:0] ep);
    sb_q.push_back({ed, ep});
    exp_frames++;
  endtask

  task automatic frame(input logic [7:0] s3, s2, s1, s0, input logic [15:0] ed, input logic [3:0] ep);
    expect_frame(ed, ep);
    slot(4'h8, s3, SC);
    slot(4'h4, s2, SC);
    slot(4'h2, s1, SC);
    slot(4'h1, s0, SC);
  endtask

  task automatic wait_frames();
    int k;
    k = 0;
    i_bit = 4'h0;
    i_seg = raw(8'h00);
    while (frames_seen < exp_frames && k < 20 * SD) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("frame_count", 32'(frames_seen), 32'(exp_frames));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_bit = 4'h0;
    i_seg = raw(8'h00);
    i_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(o_digits), 32'h0000EEEE);
    chk("rst_dp", 32'(o_dp), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_stale", 32'(o_stale), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic frame, twice.
    frame(8'h3F, 8'h86, 8'h6D, 8'h07, 16'h0157, 4'b0100);
    frame(8'h3F, 8'h86, 8'h6D, 8'h07, 16'h0157, 4'b0100);
    wait_frames();
    chk("t1_err", 32'(o_err), 32'h0);

    // Invalid pattern on slot 2, then clear.
    frame(8'h06, 8'h5C, 8'h5B, 8'h4F, 16'h1F23, 4'b0000);
    wait_frames();
    chk("t2_err_set", 32'(o_err), 32'h1);
    i_err_clr = 1'b1;
    @(posedge clk);
    #1 i_err_clr = 1'b0;
    @(negedge clk);
    chk("t2_err_clr", 32'(o_err), 32'h0);

    // Slot 2 only held STABLE_CNT-1 samples: no frame until it settles.
    slot(4'h8, 8'h3F, SC);
    slot(4'h4, 8'h7D, SC - 1);
    slot(4'h2, 8'h4F, SC);
    slot(4'h1, 8'h66, SC);
    idle(40);
    chk("t3_no_frame", 32'(frames_seen), 32'(exp_frames));
    expect_frame(16'h0434, 4'b0000);
    slot(4'h4, 8'h66, SC);
    wait_frames();

    // Re-accept of slot 3 with a new value overwrites the shadow.
    expect_frame(16'h1234, 4'b0000);
    slot(4'h8, 8'h3F, SC);
    slot(4'h8, 8'h06, SC);
    slot(4'h4, 8'h5B, SC);
    slot(4'h2, 8'h4F, SC);
    slot(4'h1, 8'h66, SC);
    wait_frames();
    chk("t_reacc_err", 32'(o_err), 32'h0);

    // Non-one-hot select mid-frame is ignored.
    expect_frame(16'h9867, 4'b0000);
    slot(4'h8, 8'h6F, SC);
    slot(4'h4, 8'h7F, SC);
    slot(4'b0110, 8'h3F, 100);
    slot(4'h2, 8'h7D, SC);
    slot(4'h1, 8'h07, SC);
    wait_frames();
    chk("t4_err", 32'(o_err), 32'h0);

    // Edit-flash frame, then scan stops until stale.
    frame(8'h80, 8'h00, 8'h86, 8'h3F, 16'hEE10, 4'b1010);
    wait_frames();
    idle(TMO - 200);
    chk("t5_not_stale", 32'(o_stale), 32'h0);
    idle(300);
    chk("t5_stale", 32'(o_stale), 32'h1);
    chk("t5_hold_digits", 32'(o_digits), 32'h0000EE10);
    chk("t5_hold_dp", 32'(o_dp), 32'hA);
    frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 16'h0000, 4'b0000);
    wait_frames();
    chk("t5_resume_stale", 32'(o_stale), 32'h0);

    // Reset with three slots captured discards the partial frame.
    slot(4'h4, 8'h5C, SC);
    slot(4'h2, 8'h06, SC);
    slot(4'h1, 8'h3F, SC);
    idle(2 * SD + 4);
    chk("t6_err_pre", 32'(o_err), 32'h1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_digits", 32'(o_digits), 32'h0000EEEE);
    chk("t6_rst_dp", 32'(o_dp), 32'h0);
    chk("t6_rst_err", 32'(o_err), 32'h0);
    chk("t6_rst_valid", 32'(o_valid), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    slot(4'h8, 8'h3F, SC);
    idle(40);
    chk("t6_no_frame", 32'(frames_seen), 32'(exp_frames));
    frame(8'h4F, 8'h66, 8'h6D, 8'h7D, 16'h3456, 4'b0000);
    wait_frames();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
